// File: rtl/atm_txn_ctrl_if.sv
// Front-panel / actuator bundle for the ATM transaction sequencer.
// master drives switches and requests; slave (the controller) drives status and actuators.
interface atm_txn_ctrl_if #(
    parameter int unsigned BAL_W = 8
);
    logic [5:0]       sw;
    logic [BAL_W-1:0] price;
    logic             buy;
    logic             cancel;
    logic [BAL_W-1:0] balance;
    logic             led0;
    logic             reject;
    logic             short;
    logic             vend;
    logic             change_valid;
    logic [BAL_W-1:0] change_coin;
    logic             busy;

    modport master (
        output sw, price, buy, cancel,
        input  balance, led0, reject, short, vend, change_valid, change_coin, busy
    );

    modport slave (
        input  sw, price, buy, cancel,
        output balance, led0, reject, short, vend, change_valid, change_coin, busy
    );
endinterface

// File: rtl/atm_txn_ctrl.sv
// Transaction sequencer: collects one-hot deposits, vends, then pays change greedily.
// Optional idle auto-cancel in COLLECT is built only when ATM_TIMEOUT_EN is defined.
module atm_txn_ctrl #(
    parameter int unsigned BAL_W       = 8,
    parameter int unsigned MAX_BAL     = 200,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic          clk,
    input logic          rst,
    atm_txn_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    if (MAX_BAL > (2 ** BAL_W) - 1) begin : g_bad_max_bal
        $error("MAX_BAL does not fit in BAL_W bits");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    logic [1:0]       state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [5:0]       sw_q;
    logic             led0_q, reject_q, reject_d, short_q, short_d;

    logic             multi, deposit, fits;
    logic [BAL_W-1:0] value, coin;
    logic [BAL_W:0]   sum;

    assign multi   = (bus.sw & (bus.sw - 6'd1)) != 6'd0;
    assign deposit = (bus.sw != 6'd0) && !multi && (sw_q == 6'd0);

    always_comb begin
        value = '0;
        case (bus.sw)
            6'b000001: value = BAL_W'(1);
            6'b000010: value = BAL_W'(5);
            6'b000100: value = BAL_W'(10);
            6'b001000: value = BAL_W'(20);
            6'b010000: value = BAL_W'(50);
            6'b100000: value = BAL_W'(100);
            default:   value = '0;
        endcase
    end

    // Widened by one bit so the ceiling test cannot wrap.
    assign sum  = {1'b0, balance_q} + {1'b0, value};
    assign fits = sum <= (BAL_W + 1)'(MAX_BAL);

    always_comb begin
        if      (balance_q >= BAL_W'(100)) coin = BAL_W'(100);
        else if (balance_q >= BAL_W'(50))  coin = BAL_W'(50);
        else if (balance_q >= BAL_W'(20))  coin = BAL_W'(20);
        else if (balance_q >= BAL_W'(10))  coin = BAL_W'(10);
        else if (balance_q >= BAL_W'(5))   coin = BAL_W'(5);
        else if (balance_q >= BAL_W'(1))   coin = BAL_W'(1);
        else                               coin = '0;
    end

`ifdef ATM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    // Counts only uninterrupted idle cycles spent in COLLECT; any activity or state change clears.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_COLLECT && state_d == ST_COLLECT && !deposit && !bus.buy) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        reject_d  = 1'b0;
        short_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (bus.cancel && state_q == ST_COLLECT) begin
                    state_d = ST_CHANGE;
                end else if (deposit) begin
                    if (fits) begin
                        balance_d = sum[BAL_W-1:0];
                        state_d   = ST_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (bus.buy && !bus.cancel) begin
                    // In IDLE balance is 0, so only a zero price vends.
                    if (balance_q >= bus.price) begin
                        balance_d = balance_q - bus.price;
                        state_d   = ST_VEND;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (state_q == ST_COLLECT && !bus.buy && timeout) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_VEND: begin
                reject_d = deposit;
                state_d  = (balance_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_d  = deposit;
                balance_d = balance_q - coin;
                if (balance_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            balance_q <= '0;
            sw_q      <= '0;
            led0_q    <= 1'b0;
            reject_q  <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            sw_q      <= bus.sw;
            led0_q    <= multi;
            reject_q  <= reject_d;
            short_q   <= short_d;
        end
    end

    assign bus.balance      = balance_q;
    assign bus.led0         = led0_q;
    assign bus.reject       = reject_q;
    assign bus.short        = short_q;
    assign bus.vend         = (state_q == ST_VEND);
    assign bus.change_valid = (state_q == ST_CHANGE);
    assign bus.change_coin  = (state_q == ST_CHANGE) ? coin : '0;
    assign bus.busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
endmodule
